// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 16x-oversampled UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined).
// Latency: line to FSM 2 cycles; rx_int rises at mid start bit; rx_data/rx_valid update at mid stop bit.
// Backpressure: none. rx_data holds its value until the next frame completes, so the consumer sees it stable around the rx_int fall.
module uart_rx_sampler #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rs232_rx,
  output logic [7:0] rx_data,
  output logic       rx_int,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_rx_sampler: CLK_FREQ/(BAUD*OVERSAMPLE) must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q, hist_q;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [3:0]      samp_cnt_q, samp_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic            s7_q, s7_d, s8_q, s8_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_int_q, rx_int_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            parity_err_q, parity_err_d;
  logic            par_err_q, par_err_d;

  logic line_s, fall, tick, mid_tick, end_tick, maj;

  assign line_s   = sync2_q;
  assign fall     = hist_q & ~sync2_q;
  assign tick     = (state_q != S_IDLE) && (div_cnt_q == DIV_MAX);
  assign mid_tick = tick && (samp_cnt_q == 4'd9);
  assign end_tick = tick && (samp_cnt_q == 4'd15);
  // Ticks 7 and 8 are held in s7/s8; tick 9 uses the live synchronized line.
  assign maj      = (s7_q & s8_q) | (s7_q & line_s) | (s8_q & line_s);

  // Two-flop synchronizer plus history flop; idle line is high.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= rs232_rx;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // FSM state, counters, shift register and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      div_cnt_q    <= '0;
      samp_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      s7_q         <= 1'b0;
      s8_q         <= 1'b0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_int_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      par_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      s7_q         <= s7_d;
      s8_q         <= s8_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_int_q     <= rx_int_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      par_err_q    <= par_err_d;
    end
  end

  // Next-state logic: baud timing, mid-bit sampling and frame sequencing.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    samp_cnt_d   = samp_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    s7_d         = s7_q;
    s8_d         = s8_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_int_d     = rx_int_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    par_err_d    = par_err_q;

    if (state_q != S_IDLE) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      if (tick) begin
        samp_cnt_d = samp_cnt_q + 4'd1;
        if (samp_cnt_q == 4'd7) s7_d = line_s;
        if (samp_cnt_q == 4'd8) s8_d = line_s;
      end
    end

    case (state_q)
      S_IDLE: begin
        // Counters held at zero so START always begins a fresh bit window.
        div_cnt_d  = '0;
        samp_cnt_d = '0;
        bit_cnt_d  = '0;
        par_err_d  = 1'b0;
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (mid_tick) begin
          if (!maj) begin
            state_d   = S_DATA;
            rx_int_d  = 1'b1;
            bit_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        // The tail of the start bit (ticks 10..15) is also spent here; bit_cnt
        // only reaches 8 after the last data bit, so that tail is harmless.
        if (mid_tick && (bit_cnt_q < 4'd8)) begin
          shift_d   = {maj, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (end_tick && (bit_cnt_q == 4'd8)) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (mid_tick) par_err_d = maj ^ (^shift_q);
        if (end_tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Finish at mid-stop so a back-to-back start edge is not missed.
        if (mid_tick) begin
          rx_data_d    = shift_q;
          rx_int_d     = 1'b0;
          rx_valid_d   = maj & ~par_err_q;
          frame_err_d  = ~maj;
          parity_err_d = par_err_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_data    = rx_data_q;
  assign rx_int     = rx_int_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed frames into uart_rx_sampler at DIV=10 (160 cycles per bit).
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_uart_rx_sampler;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       rs232_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_int, rx_valid, frame_err, parity_err;

  uart_rx_sampler #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .rs232_rx  (rs232_rx),
    .rx_data   (rx_data),
    .rx_int    (rx_int),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int         n_rise = 0, n_fall = 0, n_valid = 0, n_vcyc = 0, n_ferr = 0, n_perr = 0;
  int         rise_cyc = 0, start_cyc = 0;
  logic [7:0] last_vdata = 8'h00, prev_vdata = 8'h00;
  logic       int_p = 1'b0, val_p = 1'b0, fe_p = 1'b0, pe_p = 1'b0;

  always @(negedge sys_clk) begin
    if (rx_int === 1'b1 && int_p === 1'b0) begin n_rise++; rise_cyc = cyc; end
    if (rx_int === 1'b0 && int_p === 1'b1) n_fall++;
    if (rx_valid === 1'b1) begin
      n_vcyc++;
      if (val_p === 1'b0) begin
        n_valid++;
        prev_vdata = last_vdata;
        last_vdata = rx_data;
      end
    end
    if (frame_err === 1'b1 && fe_p === 1'b0) n_ferr++;
    if (parity_err === 1'b1 && pe_p === 1'b0) n_perr++;
    int_p = rx_int;
    val_p = rx_valid;
    fe_p  = frame_err;
    pe_p  = parity_err;
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame; the line is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic pflip);
    start_cyc = cyc;
    rs232_rx = 1'b0;
    step(160);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = d[i];
      step(160);
    end
`ifdef UART_RX_PARITY_EN
    rs232_rx = (^d) ^ pflip;
    step(160);
`else
    if (pflip) rs232_rx = 1'b1;
`endif
    rs232_rx = stop_v;
    step(160);
  endtask

  int s_rise, s_fall, s_valid, s_vcyc, s_ferr, s_perr;

  task automatic snap();
    s_rise = n_rise; s_fall = n_fall; s_valid = n_valid;
    s_vcyc = n_vcyc; s_ferr = n_ferr; s_perr = n_perr;
  endtask

  initial begin
    // Reset values
    step(3);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_int", 32'(rx_int), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    sys_rst = 1'b0;
    step(50);

    // 1: 0xA5
    snap();
    send_frame(8'hA5, 1'b1, 1'b0);
    step(20);
    check("t1_valid_pulses", 32'(n_valid - s_valid), 32'd1);
    check("t1_valid_cycles", 32'(n_vcyc - s_vcyc), 32'd1);
    check("t1_data", 32'(last_vdata), 32'hA5);
    check("t1_ferr", 32'(n_ferr - s_ferr), 32'd0);
    check("t1_int_fall", 32'(n_fall - s_fall), 32'd1);
    check("t1_rise_near_midstart",
          32'((rise_cyc - start_cyc >= 88) && (rise_cyc - start_cyc <= 108)), 32'd1);
    check("t1_int_low", 32'(rx_int), 32'h0);

    // 2: 40-cycle glitch then a good 0x11
    snap();
    rs232_rx = 1'b0;
    step(40);
    rs232_rx = 1'b1;
    step(300);
    check("t2_no_rise", 32'(n_rise - s_rise), 32'd0);
    check("t2_no_valid", 32'(n_valid - s_valid), 32'd0);
    send_frame(8'h11, 1'b1, 1'b0);
    step(20);
    check("t2_valid_after", 32'(n_valid - s_valid), 32'd1);
    check("t2_data", 32'(last_vdata), 32'h11);

    // 3: 0x3C with low stop bit, line held low
    snap();
    send_frame(8'h3C, 1'b0, 1'b0);
    step(400);
    check("t3_ferr", 32'(n_ferr - s_ferr), 32'd1);
    check("t3_no_valid", 32'(n_valid - s_valid), 32'd0);
    check("t3_rx_data", 32'(rx_data), 32'h3C);
    check("t3_one_frame", 32'(n_rise - s_rise), 32'd1);
    rs232_rx = 1'b1;
    step(400);
    check("t3_no_rearm_on_rise", 32'(n_rise - s_rise), 32'd1);

    // 4: 0x00 then 0xFF back to back
    snap();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    step(20);
    check("t4_valid_pulses", 32'(n_valid - s_valid), 32'd2);
    check("t4_first", 32'(prev_vdata), 32'h00);
    check("t4_second", 32'(last_vdata), 32'hFF);
    check("t4_int_falls", 32'(n_fall - s_fall), 32'd2);

    // 5: reset during data bit 4 of an aborted 0xF0, then 0x5A
    rs232_rx = 1'b0;
    step(160);
    for (int i = 0; i < 4; i++) begin
      rs232_rx = 1'b0;
      step(160);
    end
    rs232_rx = 1'b1;
    step(80);
    check("t5_int_before_rst", 32'(rx_int), 32'h1);
    sys_rst = 1'b1;
    step(1);
    sys_rst = 1'b0;
    check("t5_int_after_rst", 32'(rx_int), 32'h0);
    check("t5_data_after_rst", 32'(rx_data), 32'h00);
    step(1500);
    snap();
    send_frame(8'h5A, 1'b1, 1'b0);
    step(20);
    check("t5_valid", 32'(n_valid - s_valid), 32'd1);
    check("t5_data", 32'(last_vdata), 32'h5A);

    // 6: parity
`ifdef UART_RX_PARITY_EN
    snap();
    send_frame(8'h81, 1'b1, 1'b1);
    step(20);
    check("t6_perr", 32'(n_perr - s_perr), 32'd1);
    check("t6_no_valid", 32'(n_valid - s_valid), 32'd0);
    snap();
    send_frame(8'h81, 1'b1, 1'b0);
    step(20);
    check("t6_valid", 32'(n_valid - s_valid), 32'd1);
    check("t6_no_perr", 32'(n_perr - s_perr), 32'd0);
    check("t6_data", 32'(last_vdata), 32'h81);
`else
    check("t6_perr_never", 32'(n_perr), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
